// File: rtl/capture_buffer.sv
// -----------------------------------------------------------------------------
// capture_buffer
//
// Purpose:
//   Sample storage stage sitting behind trigger_node. While capturing, each
//   probe word qualified by wt_ce/wt_en is written into a circular RAM at the
//   trigger_node write address. Once stop_flag arrives the window is frozen.
//   A later readout drains it oldest-first through a one-cycle read port that
//   feeds the cfg_int shift-out logic. Single clock domain (trig_clk).
//
// Optional build macro:
//   CAPTURE_BUF_PARITY_EN - store an even-parity bit with every word and
//                           report mismatches on rd_perr. When undefined,
//                           rd_perr is constant 0.
//
// Ports:
//   trig_clk    in   capture clock
//   trig_rst    in   asynchronous reset, active-high
//   arm         in   pulse; starts a new capture from IDLE
//   sample_din  in   probe word sampled this cycle
//   wt_ce       in   write chip enable from trigger_node
//   wt_en       in   write enable from trigger_node
//   wt_addr     in   write address; low ADDR_WIDTH bits used
//   stop_flag   in   capture complete (level)
//   stop_addr   in   last written address; low ADDR_WIDTH bits used
//   rd_start    in   pulse; begin readout from DONE
//   rd_req      in   request one word while in READ
//   rd_valid    out  rd_data valid this cycle
//   rd_data     out  read word (held while rd_valid=0)
//   rd_last     out  final word of the window
//   rd_perr     out  parity error on the current rd_data
//   sample_cnt  out  words captured, saturating at DEPTH
//   state_o     out  0 IDLE, 1 CAPTURE, 2 DONE, 3 READ
// -----------------------------------------------------------------------------
module capture_buffer #(
    parameter int DATA_WIDTH = 97,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  trig_clk,
    input  logic                  trig_rst,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] sample_din,
    input  logic                  wt_ce,
    input  logic                  wt_en,
    input  logic [15:0]           wt_addr,
    input  logic                  stop_flag,
    input  logic [15:0]           stop_addr,
    input  logic                  rd_start,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_perr,
    output logic [ADDR_WIDTH:0]   sample_cnt,
    output logic [1:0]            state_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef CAPTURE_BUF_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_READ    = 2'd3;

    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_sample_cnt;
    logic [ADDR_WIDTH-1:0] r_stop_addr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic                  r_rd_perr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [MEM_W-1:0]      r_mem [DEPTH];

    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [MEM_W-1:0]      w_wr_word;
    logic                  w_rd_issue;
    logic [MEM_W-1:0]      w_rd_word;
    logic                  w_perr;
    logic                  w_unused_addr_hi;

    // Upper address bits from trigger_node carry no meaning here; the address
    // simply wraps modulo DEPTH.
    assign w_unused_addr_hi = ^{wt_addr[15:ADDR_WIDTH], stop_addr[15:ADDR_WIDTH]};

    assign w_wr_en    = (r_state == ST_CAPTURE) && wt_ce && wt_en;
    assign w_wr_addr  = wt_addr[ADDR_WIDTH-1:0];
    assign w_rd_issue = (r_state == ST_READ) && rd_req && (r_remaining != CNT_ZERO);
    assign w_rd_word  = r_mem[r_rd_ptr];

`ifdef CAPTURE_BUF_PARITY_EN
    // Even parity: the stored bit makes the total count of ones even, so a
    // clean word recomputes to the same bit.
    assign w_wr_word = {^sample_din, sample_din};
    assign w_perr    = w_rd_word[DATA_WIDTH] ^ (^w_rd_word[DATA_WIDTH-1:0]);
`else
    assign w_wr_word = sample_din;
    assign w_perr    = 1'b0;
`endif

    // NOTE: the sample RAM has no reset; clearing thousands of words would
    // prevent block-RAM mapping and a stale window is never read because
    // readout is bounded by sample_cnt.
    always_ff @(posedge trig_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, independent of statement
    // order.
    always_ff @(posedge trig_clk or posedge trig_rst) begin
        if (trig_rst) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_stop_addr  <= '0;
            r_rd_ptr     <= '0;
            r_remaining  <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_perr    <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            // Read strobes are single-cycle; rd_data itself is held.
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_perr  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state      <= ST_CAPTURE;
                        r_sample_cnt <= '0;
                    end
                end

                ST_CAPTURE: begin
                    // A write coincident with stop_flag is still committed.
                    if (w_wr_en && (r_sample_cnt != CNT_FULL)) begin
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                    end
                    if (stop_flag) begin
                        r_state     <= ST_DONE;
                        r_stop_addr <= stop_addr[ADDR_WIDTH-1:0];
                    end
                end

                ST_DONE: begin
                    if (arm) begin
                        r_state <= ST_IDLE;
                    end else if (rd_start) begin
                        if (r_sample_cnt != CNT_ZERO) begin
                            r_state     <= ST_READ;
                            r_remaining <= r_sample_cnt;
                            // A full buffer has wrapped: the oldest word sits
                            // just after the last one written.
                            r_rd_ptr    <= (r_sample_cnt == CNT_FULL) ?
                                           (r_stop_addr + 1'b1) : '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_READ: begin
                    if (w_rd_issue) begin
                        r_rd_valid  <= 1'b1;
                        r_rd_data   <= w_rd_word[DATA_WIDTH-1:0];
                        r_rd_perr   <= w_perr;
                        r_rd_last   <= (r_remaining == CNT_ONE);
                        r_rd_ptr    <= r_rd_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == CNT_ONE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign rd_last    = r_rd_last;
    assign rd_perr    = r_rd_perr;
    assign sample_cnt = r_sample_cnt;
    assign state_o    = r_state;

endmodule

// File: tb/tb_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_capture_buffer
//
// Purpose:
//   Self-checking bench for capture_buffer with ADDR_WIDTH=4 (DEPTH=16).
//   A table of capture scenarios is replayed: each fills the buffer, stops,
//   and drains it, comparing every word against a shadow copy of the RAM.
//   Hand-written sequences cover the empty capture, arm priority in DONE and
//   reset during readout.
// -----------------------------------------------------------------------------
module tb_capture_buffer;

    localparam int DW = 97;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          trig_clk = 1'b0;
    logic          trig_rst;
    logic          arm;
    logic [DW-1:0] sample_din;
    logic          wt_ce;
    logic          wt_en;
    logic [15:0]   wt_addr;
    logic          stop_flag;
    logic [15:0]   stop_addr;
    logic          rd_start;
    logic          rd_req;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_perr;
    logic [AW:0]   sample_cnt;
    logic [1:0]    state_o;

    capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .trig_clk   (trig_clk),
        .trig_rst   (trig_rst),
        .arm        (arm),
        .sample_din (sample_din),
        .wt_ce      (wt_ce),
        .wt_en      (wt_en),
        .wt_addr    (wt_addr),
        .stop_flag  (stop_flag),
        .stop_addr  (stop_addr),
        .rd_start   (rd_start),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_perr    (rd_perr),
        .sample_cnt (sample_cnt),
        .state_o    (state_o)
    );

    always #5 trig_clk = ~trig_clk;

    typedef struct {
        string         name;
        int            n_writes;
        int            base;
        logic [DW-1:0] hi_mask;
        int            stop_addr;
        bit            stop_with_last;
        bit            gaps;
        bit            rand_data;
        int            exp_cnt;
    } cap_vec_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_mem [DEPTH];
    cap_vec_t      vecs [5];
    cap_vec_t      v_small;
    cap_vec_t      v_rst;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the active edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge trig_clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm        = 1'b0;
        sample_din = '0;
        wt_ce      = 1'b0;
        wt_en      = 1'b0;
        wt_addr    = '0;
        stop_flag  = 1'b0;
        stop_addr  = '0;
        rd_start   = 1'b0;
        rd_req     = 1'b0;
    endtask

    // Arm, write n words at addr i mod 16 (upper address bits garbage),
    // stop, then poke DONE with a write and rd_req that must be ignored.
    task automatic capture_run(input cap_vec_t v);
        logic [DW-1:0] d;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check({v.name, "_arm_state"}, 128'(state_o), 128'(1));
        check({v.name, "_arm_cnt"}, 128'(sample_cnt), 128'(0));
        rd_req = 1'b1;
        for (int i = 0; i < v.n_writes; i++) begin
            if (v.rand_data) d = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
            else             d = DW'(v.base + i) | v.hi_mask;
            wt_ce      = 1'b1;
            wt_en      = 1'b1;
            wt_addr    = {12'hA5C, 4'(i)};
            sample_din = d;
            model_mem[i % DEPTH] = d;
            arm        = (i == 1);
            stop_flag  = v.stop_with_last && (i == v.n_writes - 1);
            stop_addr  = 16'(v.stop_addr) | 16'hF000;
            cycle();
            if (i == 2) check({v.name, "_cap_state"}, 128'(state_o), 128'(1));
            check({v.name, "_cap_no_valid"}, 128'(rd_valid), 128'(0));
        end
        wt_ce = 1'b0;
        wt_en = 1'b0;
        arm   = 1'b0;
        if (!v.stop_with_last) begin
            stop_flag = 1'b1;
            stop_addr = 16'(v.stop_addr) | 16'hF000;
            cycle();
        end
        stop_flag = 1'b0;
        check({v.name, "_done_state"}, 128'(state_o), 128'(2));
        check({v.name, "_done_cnt"}, 128'(sample_cnt), 128'(v.exp_cnt));
        // Write aimed at the first word to be read: must not land.
        wt_ce      = 1'b1;
        wt_en      = 1'b1;
        wt_addr    = 16'((v.exp_cnt == DEPTH) ? (v.stop_addr + 1) % DEPTH : 0);
        sample_din = '1;
        cycle();
        wt_ce = 1'b0;
        wt_en = 1'b0;
        check({v.name, "_done_hold"}, 128'(state_o), 128'(2));
        check({v.name, "_done_cnt2"}, 128'(sample_cnt), 128'(v.exp_cnt));
        check({v.name, "_done_no_valid"}, 128'(rd_valid), 128'(0));
        rd_req = 1'b0;
    endtask

    task automatic readout(input cap_vec_t v);
        int            start;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] exp_prev;
        start    = (v.exp_cnt == DEPTH) ? (v.stop_addr + 1) % DEPTH : 0;
        exp_prev = '0;
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        check({v.name, "_read_state"}, 128'(state_o), 128'(3));
        check({v.name, "_read_no_valid"}, 128'(rd_valid), 128'(0));
        for (int k = 0; k < v.exp_cnt; k++) begin
            if (v.gaps && (k % 2 == 1)) begin
                rd_req = 1'b0;
                cycle();
                check($sformatf("%s_gap_valid%0d", v.name, k), 128'(rd_valid), 128'(0));
                check($sformatf("%s_gap_hold%0d", v.name, k), 128'(rd_data), 128'(exp_prev));
            end
            rd_req = 1'b1;
            cycle();
            exp_d = model_mem[(start + k) % DEPTH];
            check($sformatf("%s_valid%0d", v.name, k), 128'(rd_valid), 128'(1));
            check($sformatf("%s_data%0d", v.name, k), 128'(rd_data), 128'(exp_d));
            check($sformatf("%s_last%0d", v.name, k), 128'(rd_last), 128'(k == v.exp_cnt - 1));
            check($sformatf("%s_state%0d", v.name, k), 128'(state_o),
                  128'((k == v.exp_cnt - 1) ? 0 : 3));
            check($sformatf("%s_perr%0d", v.name, k), 128'(rd_perr), 128'(0));
            exp_prev = exp_d;
        end
        // rd_req still high: excess requests after rd_last are ignored.
        cycle();
        check({v.name, "_excess_valid"}, 128'(rd_valid), 128'(0));
        check({v.name, "_excess_hold"}, 128'(rd_data), 128'(exp_prev));
        check({v.name, "_excess_state"}, 128'(state_o), 128'(0));
        rd_req = 1'b0;
    endtask

    initial begin
        //           name     n   base   hi_mask            stop  sw  gap rnd cnt
        vecs[0] = '{"partial", 5, 'h11, '0,                 4,    0,  0,  0,  5};
        vecs[1] = '{"wrap",    20, 0,   '0,                 3,    0,  1,  0,  16};
        vecs[2] = '{"simstop", 8, 'hA3, '0,                 7,    1,  0,  0,  8};
        vecs[3] = '{"full",    16, 'h100, DW'(1) << (DW-1), 15,   0,  0,  0,  16};
        vecs[4] = '{"satrand", 37, 0,   '0,                 4,    0,  1,  1,  16};
        v_small = '{"prio",    3, 'h40, '0,                 2,    0,  0,  0,  3};
        v_rst   = '{"rstread", 8, 'h60, '0,                 7,    0,  0,  0,  8};

        idle_inputs();
        trig_rst = 1'b1;
        repeat (2) cycle();
        check("rst_state", 128'(state_o), 128'(0));
        check("rst_cnt", 128'(sample_cnt), 128'(0));
        check("rst_valid", 128'(rd_valid), 128'(0));
        check("rst_last", 128'(rd_last), 128'(0));
        check("rst_perr", 128'(rd_perr), 128'(0));
        check("rst_data", 128'(rd_data), 128'(0));
        trig_rst = 1'b0;
        cycle();

        // IDLE ignores everything except arm.
        rd_req    = 1'b1;
        rd_start  = 1'b1;
        stop_flag = 1'b1;
        wt_ce     = 1'b1;
        wt_en     = 1'b1;
        cycle();
        check("idle_state", 128'(state_o), 128'(0));
        check("idle_valid", 128'(rd_valid), 128'(0));
        check("idle_cnt", 128'(sample_cnt), 128'(0));
        idle_inputs();

        for (int t = 0; t < 5; t++) begin
            capture_run(vecs[t]);
            readout(vecs[t]);
        end

        // Empty capture: rd_start with sample_cnt==0 goes straight to IDLE.
        arm = 1'b1;
        cycle();
        arm       = 1'b0;
        stop_flag = 1'b1;
        cycle();
        stop_flag = 1'b0;
        check("empty_done", 128'(state_o), 128'(2));
        check("empty_cnt", 128'(sample_cnt), 128'(0));
        rd_start = 1'b1;
        rd_req   = 1'b1;
        cycle();
        rd_start = 1'b0;
        check("empty_idle", 128'(state_o), 128'(0));
        check("empty_valid", 128'(rd_valid), 128'(0));
        cycle();
        check("empty_valid2", 128'(rd_valid), 128'(0));
        rd_req = 1'b0;

        // arm beats rd_start in DONE.
        capture_run(v_small);
        arm      = 1'b1;
        rd_start = 1'b1;
        cycle();
        arm      = 1'b0;
        rd_start = 1'b0;
        check("prio_idle", 128'(state_o), 128'(0));
        check("prio_valid", 128'(rd_valid), 128'(0));
        cycle();
        check("prio_stay_idle", 128'(state_o), 128'(0));

        // Reset after 3 of 8 words.
        capture_run(v_rst);
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        rd_req   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("rstread_data%0d", k), 128'(rd_data), 128'(model_mem[k]));
        end
        check("rstread_pre_valid", 128'(rd_valid), 128'(1));
        #2;
        trig_rst = 1'b1;
        #1;
        check("rstread_valid", 128'(rd_valid), 128'(0));
        check("rstread_state", 128'(state_o), 128'(0));
        check("rstread_cnt", 128'(sample_cnt), 128'(0));
        check("rstread_data", 128'(rd_data), 128'(0));
        cycle();
        trig_rst = 1'b0;
        cycle();
        check("post_rst_valid", 128'(rd_valid), 128'(0));
        check("post_rst_state", 128'(state_o), 128'(0));
        rd_req = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
